// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: Moore FSM driving shared-datapath selects and enables.
// Optional MIPS_CTRL_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       retire,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur_state;
    state_t nxt_state;
    state_t dec_state;
    logic   mrdy;
    logic   funct_legal;
    logic [2:0] funct_alu;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign mrdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mrdy = 1'b1;
`endif

    // R-type funct decode to ALU operation
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    assign state = 4'(cur_state);

    // During reset the FETCH decode is shown, with every enable masked below
    assign dec_state = reset ? S_FETCH : cur_state;

    always_comb begin
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        nxt_state   = S_FETCH;
        case (dec_state)
            S_FETCH: begin
                ir_write    = mrdy;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                pc_en       = mrdy;
                nxt_state   = mrdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
                if (op == OP_LW || op == OP_SW)          nxt_state = S_MEMADR;
                else if (op == OP_RTYPE && funct_legal) nxt_state = S_EXECUTE;
                else if (op == OP_BEQ)                  nxt_state = S_BRANCH;
                else if (op == OP_ADDI)                 nxt_state = S_ADDIEXEC;
                else if (op == OP_J)                    nxt_state = S_JUMP;
                else                                    nxt_state = S_HALT;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                nxt_state   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                iord      = 1'b1;
                nxt_state = mrdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mrdy;
                nxt_state = mrdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                nxt_state   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = zero;
                retire      = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                nxt_state   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            S_HALT: begin
                halted    = 1'b1;
                nxt_state = S_HALT;
            end
            default: nxt_state = S_FETCH;
        endcase
        if (reset) begin
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: driver queues per-cycle expected outputs, monitor compares.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, retire, halted;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .ir_write(ir_write), .mem_write(mem_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
        .retire(retire), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // st | iord ir_write mem_write reg_dst mem_to_reg reg_write alu_src_a | alu_src_b | alu_control | pc_src | pc_en retire halted
    typedef logic [20:0] exp_t;

    localparam exp_t E_FETCH    = {4'd0,  7'b0100000, 2'b01, 3'b010, 2'b00, 3'b100};
    localparam exp_t E_DECODE   = {4'd1,  7'b0000000, 2'b11, 3'b010, 2'b00, 3'b000};
    localparam exp_t E_MEMADR   = {4'd2,  7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam exp_t E_MEMREAD  = {4'd3,  7'b1000000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam exp_t E_MEMWB    = {4'd4,  7'b0000110, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam exp_t E_MEMWRITE = {4'd5,  7'b1010000, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam exp_t E_ALUWB    = {4'd7,  7'b0001010, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam exp_t E_BR_TAKEN = {4'd8,  7'b0000001, 2'b00, 3'b110, 2'b01, 3'b110};
    localparam exp_t E_BR_NOT   = {4'd8,  7'b0000001, 2'b00, 3'b110, 2'b01, 3'b010};
    localparam exp_t E_ADDIEX   = {4'd9,  7'b0000001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam exp_t E_ADDIWB   = {4'd10, 7'b0000010, 2'b00, 3'b000, 2'b00, 3'b010};
    localparam exp_t E_JUMP     = {4'd11, 7'b0000000, 2'b00, 3'b000, 2'b10, 3'b110};
    localparam exp_t E_HALT     = {4'd12, 7'b0000000, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam exp_t E_FETCH_WT = {4'd0,  7'b0000000, 2'b01, 3'b010, 2'b00, 3'b000};
    localparam exp_t E_MEMWR_WT = {4'd5,  7'b1010000, 2'b00, 3'b000, 2'b00, 3'b000};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mr_free = 1'b1;

    // Reset-cycle outputs: FETCH decode with enables masked, state register as-is
    function automatic exp_t rst_exp(input logic [3:0] st);
        return {st, 7'b0000000, 2'b01, 3'b010, 2'b00, 3'b000};
    endfunction

    function automatic exp_t ex_exp(input logic [2:0] alu);
        return {4'd6, 7'b0000001, 2'b00, alu, 2'b00, 3'b000};
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input exp_t e, input string nm);
        reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // mem_ready is toggled freely unless the wait feature makes it meaningful
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input exp_t e, input string nm);
`ifdef MIPS_CTRL_MEM_WAIT_EN
        mr_free = 1'b1;
`else
        mr_free = ~mr_free;
`endif
        cyc(1'b0, o, f, z, mr_free, e, nm);
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] alu, input string nm);
        step(OP_R, f, 1'b1, E_FETCH, {nm, "_fetch"});
        step(OP_R, f, 1'b0, E_DECODE, {nm, "_decode"});
        step(OP_R, f, 1'b1, ex_exp(alu), {nm, "_exec"});
        step(OP_R, f, 1'b0, E_ALUWB, {nm, "_aluwb"});
    endtask

    task automatic run_lw(input string nm);
        step(OP_LW, 6'h00, 1'b0, E_FETCH, {nm, "_fetch"});
        step(OP_LW, 6'h00, 1'b0, E_DECODE, {nm, "_decode"});
        step(OP_LW, 6'h00, 1'b1, E_MEMADR, {nm, "_memadr"});
        step(OP_LW, 6'h00, 1'b0, E_MEMREAD, {nm, "_memread"});
        step(OP_LW, 6'h00, 1'b0, E_MEMWB, {nm, "_memwb"});
    endtask

    initial begin
        reset = 1'b1; op = OP_R; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, OP_R, 6'b100000, 1'b0, 1'b1, rst_exp(4'd0), "reset_hold");
        step(OP_R, 6'b100000, 1'b0, E_FETCH, "first_fetch");
        step(OP_R, 6'b100000, 1'b0, E_DECODE, "first_decode");
        step(OP_R, 6'b100000, 1'b0, ex_exp(3'b010), "first_exec");
        step(OP_R, 6'b100000, 1'b0, E_ALUWB, "first_aluwb");

        run_lw("lw");
        step(OP_SW, 6'h00, 1'b0, E_FETCH, "sw_fetch");
        step(OP_SW, 6'h00, 1'b0, E_DECODE, "sw_decode");
        step(OP_SW, 6'h00, 1'b0, E_MEMADR, "sw_memadr");
        step(OP_SW, 6'h00, 1'b1, E_MEMWRITE, "sw_memwrite");

        run_rtype(6'b100000, 3'b010, "add");
        run_rtype(6'b100010, 3'b110, "sub");
        run_rtype(6'b100100, 3'b000, "and");
        run_rtype(6'b100101, 3'b001, "or");
        run_rtype(6'b101010, 3'b111, "slt");

        step(OP_BEQ, 6'h00, 1'b0, E_FETCH, "beq1_fetch");
        step(OP_BEQ, 6'h00, 1'b0, E_DECODE, "beq1_decode");
        step(OP_BEQ, 6'h00, 1'b1, E_BR_TAKEN, "beq1_branch");
        step(OP_BEQ, 6'h00, 1'b1, E_FETCH, "beq0_fetch");
        step(OP_BEQ, 6'h00, 1'b1, E_DECODE, "beq0_decode");
        step(OP_BEQ, 6'h00, 1'b0, E_BR_NOT, "beq0_branch");

        step(OP_ADDI, 6'h2a, 1'b0, E_FETCH, "addi_fetch");
        step(OP_ADDI, 6'h2a, 1'b0, E_DECODE, "addi_decode");
        step(OP_ADDI, 6'h2a, 1'b0, E_ADDIEX, "addi_exec");
        step(OP_ADDI, 6'h2a, 1'b0, E_ADDIWB, "addi_wb");

        step(OP_J, 6'h00, 1'b0, E_FETCH, "j_fetch");
        step(OP_J, 6'h00, 1'b0, E_DECODE, "j_decode");
        step(OP_J, 6'h00, 1'b0, E_JUMP, "j_jump");

        // Illegal opcode halts until reset, regardless of later inputs
        step(6'b111111, 6'h00, 1'b0, E_FETCH, "ill_fetch");
        step(6'b111111, 6'h00, 1'b0, E_DECODE, "ill_decode");
        for (int i = 0; i < 10; i++)
            step((i % 2 == 0) ? OP_LW : OP_J, 6'b100000, i[0], E_HALT, "ill_halt");
        cyc(1'b1, OP_R, 6'b000000, 1'b0, 1'b1, rst_exp(4'd12), "halt_reset");

        // R-type with an illegal funct also halts
        step(OP_R, 6'b000000, 1'b0, E_FETCH, "badfn_fetch");
        step(OP_R, 6'b000000, 1'b0, E_DECODE, "badfn_decode");
        step(OP_R, 6'b000000, 1'b0, E_HALT, "badfn_halt");
        cyc(1'b1, OP_LW, 6'h00, 1'b0, 1'b1, rst_exp(4'd12), "badfn_reset");

        // Reset mid-lw abandons it without retire
        step(OP_LW, 6'h00, 1'b0, E_FETCH, "abort_fetch");
        step(OP_LW, 6'h00, 1'b0, E_DECODE, "abort_decode");
        step(OP_LW, 6'h00, 1'b0, E_MEMADR, "abort_memadr");
        cyc(1'b1, OP_LW, 6'h00, 1'b0, 1'b1, rst_exp(4'd3), "abort_reset");
        run_lw("after_abort");

`ifdef MIPS_CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++)
            cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_FETCH_WT, "wait_fetch_stall");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b1, E_FETCH, "wait_fetch_go");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_DECODE, "wait_decode");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMADR, "wait_memadr");
        for (int i = 0; i < 2; i++)
            cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMREAD, "wait_memread_stall");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b1, E_MEMREAD, "wait_memread_go");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMWB, "wait_memwb");
        cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b1, E_FETCH, "wsw_fetch");
        cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, E_DECODE, "wsw_decode");
        cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, E_MEMADR, "wsw_memadr");
        for (int i = 0; i < 2; i++)
            cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, E_MEMWR_WT, "wsw_memwrite_stall");
        cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b1, E_MEMWRITE, "wsw_memwrite_go");
        cyc(1'b0, OP_R, 6'b100000, 1'b0, 1'b1, E_FETCH, "wsw_next_fetch");
`else
        // mem_ready held low has no effect without the wait feature
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_FETCH, "nowait_fetch");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_DECODE, "nowait_decode");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMADR, "nowait_memadr");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMREAD, "nowait_memread");
        cyc(1'b0, OP_LW, 6'h00, 1'b0, 1'b0, E_MEMWB, "nowait_memwb");
        cyc(1'b0, OP_SW, 6'h00, 1'b0, 1'b0, E_FETCH, "nowait_next_fetch");
`endif

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: compare every cycle with a queued expectation, away from the rising edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {state, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_control, pc_src, pc_en, retire, halted};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%b, required st=%0d ctl=%b",
                         nm, got[20:17], got[16:0], e[20:17], e[16:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine that steps the shared datapath through fetch, decode, execute, memory and writeback cycles. One unified memory then serves both instructions and data, and one ALU serves both PC increment and execution. It sits between the instruction register (`op`/`funct` fields), the ALU `zero` flag and the datapath mux selects and write enables.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag.
- `mem_ready` in 1: memory access complete. Used only with `MIPS_CTRL_MEM_WAIT_EN`; ignored otherwise.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `mem_write` out 1: memory write enable.
- `reg_dst` out 1: write register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback data select. 0 = ALUOut, 1 = memory data register.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select. 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en` out 1: PC load enable.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `halted` out 1: high in HALT.
- `state` out 4: current state code, for debug.

## Operation
Default value of every control output is 0 unless a state lists it.

States, their outputs and their transitions:
- **FETCH (0)**: `ir_write`=1, `alu_src_b`=01, `alu_control`=010, `pc_src`=00, `pc_en`=1. Next: DECODE.
- **DECODE (1)**: `alu_src_b`=11, `alu_control`=010 (branch target goes into ALUOut). Next:
  - op 100011 or 101011 → MEMADR.
  - op 000000 with a legal funct → EXECUTE.
  - op 000100 → BRANCH.
  - op 001000 → ADDIEXEC.
  - op 000010 → JUMP.
  - anything else → HALT.
- **MEMADR (2)**: `alu_src_a`=1, `alu_src_b`=10, `alu_control`=010. Next: lw → MEMREAD, sw → MEMWRITE.
- **MEMREAD (3)**: `iord`=1. Next: MEMWB.
- **MEMWB (4)**: `mem_to_reg`=1, `reg_write`=1, `retire`=1. Next: FETCH.
- **MEMWRITE (5)**: `iord`=1, `mem_write`=1, `retire`=1. Next: FETCH.
- **EXECUTE (6)**: `alu_src_a`=1, `alu_src_b`=00. `alu_control` from funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Next: ALUWB.
- **ALUWB (7)**: `reg_dst`=1, `reg_write`=1, `retire`=1. Next: FETCH.
- **BRANCH (8)**: `alu_src_a`=1, `alu_control`=110, `pc_src`=01, `pc_en`=`zero`, `retire`=1. Next: FETCH.
- **ADDIEXEC (9)**: `alu_src_a`=1, `alu_src_b`=10, `alu_control`=010. Next: ADDIWB.
- **ADDIWB (10)**: `reg_write`=1, `retire`=1. Next: FETCH.
- **JUMP (11)**: `pc_src`=10, `pc_en`=1, `retire`=1. Next: FETCH.
- **HALT (12)**: `halted`=1, all enables 0. Remains in HALT until `reset`.

Unused state codes 13–15 go to FETCH on the next edge with all enables 0.

## Timing
- Reset:
  - The rising edge with `reset`=1 loads FETCH.
  - While `reset`=1, `ir_write`, `pc_en`, `reg_write`, `mem_write` and `retire` are forced to 0 combinationally. The other outputs show the FETCH values.
  - Reset asserted mid-instruction abandons it and does not pulse `retire`.
  - The first fetch occurs on the first edge after `reset` deasserts.
- Outputs are decoded from `state` combinationally. `pc_en` in BRANCH depends on `zero` in the same cycle.
- Cycles per instruction, FETCH through retire: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Register writes and PC loads take effect on the edge that leaves the asserting state.

## Configuration
`MIPS_CTRL_MEM_WAIT_EN` defined: FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
- FETCH: `ir_write` and `pc_en` are asserted only in a cycle where `mem_ready`=1.
- MEMWRITE: `mem_write` stays high through the whole wait. `retire` pulses only in the `mem_ready` cycle.
- MEMREAD: advances only when `mem_ready`=1.
- `mem_ready` is not sampled in any other state.

`MIPS_CTRL_MEM_WAIT_EN` undefined: `mem_ready` is ignored and every state lasts one cycle.

## Test plan
- **Reset:** hold `reset` for 2 edges with op=000000. Required: `state`=0 and `pc_en`=0, `ir_write`=0 during reset; `pc_en`=1, `ir_write`=1 in the first cycle after release.
- **lw then sw:** op=100011, then op=101011. Required states 0,1,2,3,4 then 0,1,2,5. `mem_to_reg`=1 and `reg_write`=1 in state 4. `mem_write`=1 and `iord`=1 in state 5. One `retire` per instruction.
- **R-type sweep:** funct 100000/100010/100100/100101/101010. Required: `alu_control` 010/110/000/001/111 in EXECUTE, then `reg_dst`=1, `reg_write`=1 in ALUWB.
- **beq:** op=000100 with `zero`=1, then with `zero`=0. Required: `pc_en`=1, `pc_src`=01 in BRANCH for the first; `pc_en`=0 for the second; 3 cycles each.
- **Illegal and jump:** op=111111 gives `halted`=1, frozen enables, and HALT held for 10 cycles until `reset`. op=000010 gives JUMP with `pc_src`=10, `pc_en`=1.
- **Memory wait** (`MIPS_CTRL_MEM_WAIT_EN` defined): lw with `mem_ready` low 3 cycles in FETCH and 2 in MEMREAD. Required: 10 cycles total, `pc_en` high exactly once, `mem_write` never high.
